// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the demux scan sequencer.
package demux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/demux_next_ch.sv
// Combinational channel finder: next higher enabled channel after cur,
// and the lowest enabled channel.
module demux_next_ch
    import demux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              has_nxt,
    output logic [SEL_W-1:0]  first
);

    always_comb begin
        nxt     = '0;
        has_nxt = 1'b0;
        first   = '0;
        // Walk downward so the lowest qualifying bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = SEL_W'(i);
                if (i > int'(cur)) begin
                    nxt     = SEL_W'(i);
                    has_nxt = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for the 1-to-8 demux: dwells on each enabled channel and routes din to it.
// Define DEMUX_SCAN_CONT_EN for continuous (wrap-around) scanning that ends only on stop.
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter int DW_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [DW_W-1:0]   dwell,
    input  logic              din,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] out,
    output logic              busy,
    output logic              done
);

    state_t              state;
    logic [NUM_CH-1:0]   mask_l;
    logic [DW_W-1:0]     dwell_l;
    logic [DW_W-1:0]     cnt;
    logic [NUM_CH-1:0]   mask_q;
    logic [SEL_W-1:0]    nxt;
    logic                has_nxt;
    logic [SEL_W-1:0]    first;

    // In IDLE the finder looks at the live mask to pick the starting channel;
    // during a scan it only ever sees the latched copy.
    assign mask_q = (state == SCAN) ? mask_l : ch_mask;

    demux_next_ch u_next (
        .mask    (mask_q),
        .cur     (sel),
        .nxt     (nxt),
        .has_nxt (has_nxt),
        .first   (first)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mask_l  <= '0;
            dwell_l <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    out  <= '0;
                    if (start && (ch_mask != '0)) begin
                        mask_l  <= ch_mask;
                        dwell_l <= (dwell == '0) ? DW_W'(1) : dwell;
                        sel     <= first;
                        cnt     <= '0;
                        out     <= NUM_CH'(din) << first;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        out   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cnt == dwell_l - DW_W'(1)) begin
                        cnt <= '0;
                        if (has_nxt) begin
                            sel <= nxt;
                            out <= NUM_CH'(din) << nxt;
                        end else begin
`ifdef DEMUX_SCAN_CONT_EN
                            sel <= first;
                            out <= NUM_CH'(din) << first;
`else
                            out   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end
                    end else begin
                        cnt <= cnt + DW_W'(1);
                        out <= NUM_CH'(din) << sel;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
